// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: FSM states, queued store entry, and small helpers.
package store_monitor_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, FINISHED} mon_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_entry_t;

    localparam logic [15:0] STORE_CNT_MAX = 16'hFFFF;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/store_monitor_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and a combinational head read.
module sync_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [63:0],
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        wr_entry,
    input  logic          pop,
    output entry_t        rd_entry,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign rd_entry = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/store_monitor.sv
// Taps the CPU data-memory write port, queues stores on a valid/ready stream and
// flags end-of-program once the terminating store and everything before it has drained.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADDR = 32'd16,
    parameter logic [31:0] DONE_DATA = 32'd0,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [31:0]   dataadr,
    input  logic [31:0]   writedata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_addr,
    output logic [31:0]   out_data,
    output logic [CW-1:0] count,
    output logic [15:0]   store_cnt,
    output logic          overflow,
    output logic          misaligned,
    output logic          done
);

    mon_state_t   state_q, state_d;
    logic [15:0]  store_cnt_q, store_cnt_d;
    logic         overflow_q, overflow_d;
    logic         misaligned_q, misaligned_d;

    store_entry_t wr_entry;
    store_entry_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         pop;
    logic         push_req;
    logic         push_ok;
    logic         is_done_store;

    assign wr_entry      = '{addr: dataadr, data: writedata};
    assign pop           = out_valid && out_ready;
    assign push_req      = memwrite && (state_q == RUN);
    assign push_ok       = push_req && (!fifo_full || pop);
    assign is_done_store = (dataadr == DONE_ADDR) && (writedata == DONE_DATA);

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (store_entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_ok),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        store_cnt_d  = store_cnt_q;
        overflow_d   = overflow_q;
        misaligned_d = misaligned_q;

        case (state_q)
            RUN:      if (push_req && is_done_store) state_d = DRAIN;
            DRAIN:    if (fifo_count == '0) state_d = FINISHED;
            FINISHED: state_d = FINISHED;
            default:  state_d = RUN;
        endcase

        // Every store counts; any store that does not make it into the FIFO is a drop.
        if (memwrite) begin
            if (store_cnt_q != STORE_CNT_MAX) store_cnt_d = store_cnt_q + 16'd1;
            if (!push_ok)                     overflow_d  = 1'b1;
            if (is_misaligned(dataadr))       misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            store_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_cnt_q  <= store_cnt_d;
            overflow_q   <= overflow_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign out_valid  = !fifo_empty;
    assign out_addr   = head.addr;
    assign out_data   = head.data;
    assign count      = fifo_count;
    assign store_cnt  = store_cnt_q;
    assign overflow   = overflow_q;
    assign misaligned = misaligned_q;
    assign done       = (state_q == FINISHED);

endmodule

// File: tb/tb_store_monitor.sv
// Directed test-plan scenarios followed by randomized traffic, all checked against a queue-based model.
module tb_store_monitor;
    import store_monitor_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          memwrite = 1'b0;
    logic [31:0]   dataadr = '0;
    logic [31:0]   writedata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_addr;
    logic [31:0]   out_data;
    logic [CW-1:0] count;
    logic [15:0]   store_cnt;
    logic          overflow;
    logic          misaligned;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    store_entry_t mq[$];
    int  m_cnt;
    bit  m_ovf, m_mis, m_drain, m_done;

    store_monitor #(.DEPTH(DEPTH), .DONE_ADDR(32'd16), .DONE_DATA(32'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .count      (count),
        .store_cnt  (store_cnt),
        .overflow   (overflow),
        .misaligned (misaligned),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".addr"}, 64'(out_addr), 64'(mq[0].addr));
            chk({tag, ".data"}, 64'(out_data), 64'(mq[0].data));
        end
        chk({tag, ".store_cnt"}, 64'(store_cnt), 64'(m_cnt));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".misaligned"}, 64'(misaligned), 64'(m_mis));
        chk({tag, ".done"}, 64'(done), 64'(m_done));
    endtask

    task automatic model_clear();
        mq.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_mis = 0;
        m_drain = 0;
        m_done = 0;
    endtask

    // One clock cycle: apply inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input string tag, input bit mw, input logic [31:0] adr,
                         input logic [31:0] dat, input bit rdy);
        bit pop, accept, fin, go_drain;
        store_entry_t e;
        memwrite  = mw;
        dataadr   = adr;
        writedata = dat;
        out_ready = rdy;
        e = '{addr: adr, data: dat};
        pop = (mq.size() != 0) && rdy;
        fin = m_drain && (mq.size() == 0);
        accept = 0;
        go_drain = 0;
        if (mw) begin
            if (m_cnt < 65535) m_cnt++;
            if (adr[1:0] != 2'b00) m_mis = 1;
            if (!m_drain && !m_done) begin
                if (mq.size() < DEPTH || pop) accept = 1;
                else m_ovf = 1;
                if (adr == 32'd16 && dat == 32'd0) go_drain = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back(e);
        if (fin) begin
            m_drain = 0;
            m_done = 1;
        end
        if (go_drain) m_drain = 1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Assert reset asynchronously mid-cycle, check the cleared state, release after an edge.
    task automatic do_reset(input string tag);
        memwrite = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all({tag, ".released"});
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_all("init");

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) cycle("mid", 1, 32'h40 + 32'(i * 4), 32'(i + 1), 0);
        chk("mid.count_before", 64'(count), 64'd3);
        do_reset("mid_rst");
        chk("mid.count_after", 64'(count), 64'd0);
        chk("mid.valid_after", 64'(out_valid), 64'd0);

        // Simple in-order stream with the consumer always ready
        cycle("ss0", 1, 32'h04, 32'h11, 1);
        chk("ss.head0", 64'(out_addr), 64'h04);
        cycle("ss1", 1, 32'h08, 32'h22, 1);
        chk("ss.head1", 64'(out_data), 64'h22);
        cycle("ss2", 0, 32'h0, 32'h0, 1);
        chk("ss.store_cnt", 64'(store_cnt), 64'd2);

        // Overflow: DEPTH+2 stores with the consumer stalled
        do_reset("ov_rst");
        for (int i = 0; i < DEPTH + 2; i++) cycle("ov", 1, 32'h100 + 32'(i * 4), 32'(i), 0);
        chk("ov.count", 64'(count), 64'(DEPTH));
        chk("ov.flag", 64'(overflow), 64'd1);
        chk("ov.store_cnt", 64'(store_cnt), 64'(DEPTH + 2));
        for (int i = 0; i < DEPTH; i++) begin
            chk("ov.drain_addr", 64'(out_addr), 64'(32'h100 + 32'(i * 4)));
            cycle("ov_drain", 0, 32'h0, 32'h0, 1);
        end

        // Full FIFO with a simultaneous push and pop
        do_reset("fp_rst");
        for (int i = 0; i < DEPTH; i++) cycle("fp", 1, 32'h200 + 32'(i * 4), 32'(i), 0);
        cycle("fp_both", 1, 32'h300, 32'hAA, 1);
        chk("fp.count", 64'(count), 64'(DEPTH));
        chk("fp.no_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH - 1; i++) cycle("fp_drain", 0, 32'h0, 32'h0, 1);
        chk("fp.last_addr", 64'(out_addr), 64'h300);
        cycle("fp_last", 0, 32'h0, 32'h0, 1);

        // End of program
        do_reset("eop_rst");
        cycle("eop0", 1, 32'h54, 32'd7, 0);
        cycle("eop1", 1, 32'd16, 32'd0, 0);
        cycle("eop2", 1, 32'h20, 32'd5, 0);
        chk("eop.dropped_ovf", 64'(overflow), 64'd1);
        chk("eop.count2", 64'(count), 64'd2);
        cycle("eop3", 0, 32'h0, 32'h0, 0);
        cycle("eop_pop1", 0, 32'h0, 32'h0, 1);
        chk("eop.not_done_yet", 64'(done), 64'd0);
        cycle("eop_pop2", 0, 32'h0, 32'h0, 1);
        cycle("eop_done", 0, 32'h0, 32'h0, 1);
        chk("eop.done", 64'(done), 64'd1);
        cycle("eop_late", 1, 32'h24, 32'd9, 1);
        cycle("eop_hold", 0, 32'h0, 32'h0, 1);
        chk("eop.done_hold", 64'(done), 64'd1);
        chk("eop.empty_after", 64'(count), 64'd0);

        // Misaligned store passes through unmodified
        do_reset("mis_rst");
        cycle("mis", 1, 32'h06, 32'hAB, 0);
        chk("mis.flag", 64'(misaligned), 64'd1);
        chk("mis.addr", 64'(out_addr), 64'h06);
        chk("mis.data", 64'(out_data), 64'hAB);

        // Randomized traffic in several reset-separated blocks
        for (int blk = 0; blk < 4; blk++) begin
            do_reset("rnd_rst");
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a, d;
                bit mw, rdy;
                mw  = ($urandom_range(0, 1) == 1);
                rdy = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 7) == 0) a = 32'd16;
                else a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                cycle("rnd", mw, a, d, rdy);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
